exe_stage: RTL and testbench

Execute pipeline stage of the LoongArch-32 core. Holds the ID→EX pipeline register, drives the combinational `alu` with registered operands, and merges the ALU result with an optional iterative 32-bit divider. Passes the result to MEM under the valid/allowin handshake used throughout the pipeline, stalling upstream while a divide is in flight.

---
 rtl/exe_stage.sv | 141 ++++++++++++++
 tb/tb_exe_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage: ID->EX pipeline register, operand drive to the external alu, result merge toward MEM.
// Define DIV_EN to build in the 32-cycle radix-2 restoring divider; without it divides pass through as ALU ops.
module exe_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_to_es_valid,
    output logic        es_allowin,
    input  logic [14:0] ds_alu_op,
    input  logic [3:0]  ds_div_op,
    input  logic [31:0] ds_src1,
    input  logic [31:0] ds_src2,
    input  logic [4:0]  ds_dest,
    input  logic        ds_gr_we,
    input  logic [31:0] ds_pc,
    output logic [14:0] alu_op,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    input  logic [31:0] alu_result,
    input  logic        ms_allowin,
    output logic        es_to_ms_valid,
    output logic [31:0] es_result,
    output logic [4:0]  es_dest,
    output logic        es_gr_we,
    output logic [31:0] es_pc,
    output logic        es_busy
);
    logic es_valid;
    logic es_ready_go;
    logic capture;

    assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go;
    assign capture        = ds_to_es_valid && es_allowin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid <= 1'b0;
            alu_op   <= '0;
            alu_src1 <= '0;
            alu_src2 <= '0;
            es_dest  <= '0;
            es_gr_we <= 1'b0;
            es_pc    <= '0;
        end else if (es_allowin) begin
            es_valid <= ds_to_es_valid;
            if (ds_to_es_valid) begin
                alu_op   <= ds_alu_op;
                alu_src1 <= ds_src1;
                alu_src2 <= ds_src2;
                es_dest  <= ds_dest;
                es_gr_we <= ds_gr_we;
                es_pc    <= ds_pc;
            end
        end
    end

`ifdef DIV_EN
    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

    div_state_t  state, state_nxt;
    logic [3:0]  div_op;
    logic [4:0]  cnt;
    logic [31:0] rem, quo, divisor, div_result;
    logic        q_neg, r_neg;
    logic        ds_signed, div_start;
    logic [32:0] rem_sh, diff;
    logic        take;
    logic [31:0] rem_step, quo_step, q_fin, r_fin;

    assign ds_signed = ds_div_op[0] | ds_div_op[1];
    assign div_start = capture && (ds_div_op != 4'd0);

    // remainder stays below the divisor, so the 33-bit borrow is the compare result
    assign rem_sh   = {rem, quo[31]};
    assign diff     = rem_sh - {1'b0, divisor};
    assign take     = !diff[32];
    assign rem_step = take ? diff[31:0] : rem_sh[31:0];
    assign quo_step = {quo[30:0], take};

    always_comb begin
        q_fin = q_neg ? -quo_step : quo_step;
        r_fin = r_neg ? -rem_step : rem_step;
        if (divisor == 32'd0) begin
            q_fin = 32'hFFFF_FFFF;
            r_fin = alu_src1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (div_start) state_nxt = DIV_RUN;
            DIV_RUN:  if (cnt == 5'd31) state_nxt = DIV_DONE;
            DIV_DONE: if (es_allowin) state_nxt = div_start ? DIV_RUN : DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= DIV_IDLE;
            div_op     <= '0;
            cnt        <= '0;
            rem        <= '0;
            quo        <= '0;
            divisor    <= '0;
            div_result <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) div_op <= ds_div_op;
            if (div_start) begin
                rem     <= '0;
                cnt     <= '0;
                quo     <= (ds_signed && ds_src1[31]) ? -ds_src1 : ds_src1;
                divisor <= (ds_signed && ds_src2[31]) ? -ds_src2 : ds_src2;
                q_neg   <= ds_signed && (ds_src1[31] ^ ds_src2[31]);
                r_neg   <= ds_signed && ds_src1[31];
            end else if (state == DIV_RUN) begin
                rem <= rem_step;
                quo <= quo_step;
                cnt <= cnt + 5'd1;
                if (cnt == 5'd31) div_result <= (div_op[0] | div_op[2]) ? q_fin : r_fin;
            end
        end
    end

    assign es_ready_go = (div_op == 4'd0) || (state == DIV_DONE);
    assign es_busy     = es_valid && (div_op != 4'd0) && (state != DIV_DONE);
    assign es_result   = (div_op != 4'd0) ? div_result : alu_result;
`else
    logic unused_div_op;

    assign unused_div_op = ^ds_div_op;
    assign es_ready_go   = 1'b1;
    assign es_busy       = 1'b0;
    assign es_result     = alu_result;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed and random instruction streams scored against a countdown-based stage model.
// Builds with or without DIV_EN; the model follows the same macro.
module tb_exe_stage;
`ifdef DIV_EN
    localparam bit DIV = 1'b1;
`else
    localparam bit DIV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_to_es_valid;
    logic        es_allowin;
    logic [14:0] ds_alu_op;
    logic [3:0]  ds_div_op;
    logic [31:0] ds_src1, ds_src2;
    logic [4:0]  ds_dest;
    logic        ds_gr_we;
    logic [31:0] ds_pc;
    logic [14:0] alu_op;
    logic [31:0] alu_src1, alu_src2;
    logic [31:0] alu_result;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [31:0] es_result;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic [31:0] es_pc;
    logic        es_busy;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .reset(reset),
        .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
        .ds_alu_op(ds_alu_op), .ds_div_op(ds_div_op),
        .ds_src1(ds_src1), .ds_src2(ds_src2),
        .ds_dest(ds_dest), .ds_gr_we(ds_gr_we), .ds_pc(ds_pc),
        .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_result(alu_result), .ms_allowin(ms_allowin),
        .es_to_ms_valid(es_to_ms_valid), .es_result(es_result),
        .es_dest(es_dest), .es_gr_we(es_gr_we), .es_pc(es_pc),
        .es_busy(es_busy)
    );

    localparam logic [14:0] OP_ADD = 15'd1 << 0;
    localparam logic [14:0] OP_SUB = 15'd1 << 1;
    localparam logic [3:0]  DIV_W  = 4'b0001;
    localparam logic [3:0]  MOD_W  = 4'b0010;
    localparam logic [3:0]  DIV_WU = 4'b0100;
    localparam logic [3:0]  MOD_WU = 4'b1000;

    function automatic logic [31:0] alu_model(input logic [14:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        if (op[0])  r = r | (a + b);
        if (op[1])  r = r | (a - b);
        if (op[2])  r = r | {31'd0, $signed(a) < $signed(b)};
        if (op[3])  r = r | {31'd0, a < b};
        if (op[4])  r = r | (a & b);
        if (op[5])  r = r | ~(a | b);
        if (op[6])  r = r | (a | b);
        if (op[7])  r = r | (a ^ b);
        if (op[8])  r = r | (a << b[4:0]);
        if (op[9])  r = r | (a >> b[4:0]);
        if (op[10]) r = r | 32'($signed(a) >>> b[4:0]);
        if (op[11]) r = r | b;
        return r;
    endfunction

    function automatic logic [31:0] div_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 32'd0) return (op[0] | op[2]) ? 32'hFFFF_FFFF : a;
        if (op[0]) return ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
        if (op[1]) return ovf ? 32'd0 : 32'($signed(a) % $signed(b));
        if (op[2]) return a / b;
        return a % b;
    endfunction

    always_comb alu_result = alu_model(alu_op, alu_src1, alu_src2);

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_valid;
    bit          m_div;
    int          m_wait;
    logic [31:0] m_res, m_pc;
    logic [14:0] m_op;
    logic [4:0]  m_dest;
    logic        m_we;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_div   = 1'b0;
        m_wait  = 0;
        m_op    = '0;
    endtask

    // one clock: drive at posedge+1, check at negedge, advance the model at posedge
    task automatic step(input logic v, input logic [14:0] aop, input logic [3:0] dop,
                        input logic [31:0] s1, input logic [31:0] s2, input logic msa);
        bit exp_tv, exp_al, exp_busy;
        ds_to_es_valid = v;
        ds_alu_op      = aop;
        ds_div_op      = dop;
        ds_src1        = s1;
        ds_src2        = s2;
        ds_dest        = 5'($urandom);
        ds_gr_we       = 1'($urandom);
        ds_pc          = $urandom;
        ms_allowin     = msa;
        @(negedge clk);
        exp_tv   = m_valid && (m_wait == 0);
        exp_al   = !m_valid || (exp_tv && msa);
        exp_busy = m_valid && m_div && (m_wait != 0);
        chk("es_allowin", 32'(es_allowin), 32'(exp_al));
        chk("es_to_ms_valid", 32'(es_to_ms_valid), 32'(exp_tv));
        chk("es_busy", 32'(es_busy), 32'(exp_busy));
        if (m_valid) chk("alu_op", 32'(alu_op), 32'(m_op));
        if (exp_tv) begin
            chk("es_result", es_result, m_res);
            chk("es_dest", 32'(es_dest), 32'(m_dest));
            chk("es_gr_we", 32'(es_gr_we), 32'(m_we));
            chk("es_pc", es_pc, m_pc);
        end
        @(posedge clk);
        if (exp_al) begin
            m_valid = v;
            if (v) begin
                m_op   = aop;
                m_dest = ds_dest;
                m_we   = ds_gr_we;
                m_pc   = ds_pc;
                if (DIV && dop != 4'd0) begin
                    m_div  = 1'b1;
                    m_wait = 32;
                    m_res  = div_model(dop, s1, s2);
                end else begin
                    m_div  = 1'b0;
                    m_wait = 0;
                    m_res  = alu_model(aop, s1, s2);
                end
            end
        end else if (m_valid && m_wait != 0) begin
            m_wait--;
        end
        #1;
    endtask

    task automatic idle(input int n, input logic msa);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, msa);
    endtask

    task automatic do_div(input logic [3:0] dop, input logic [31:0] a, input logic [31:0] b);
        step(1'b1, '0, dop, a, b, 1'b1);
        idle(34, 1'b1);
    endtask

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] t;
        case ($urandom_range(0, 5))
            0: t = 32'd0;
            1: t = 32'h8000_0000;
            2: t = 32'hFFFF_FFFF;
            3: t = 32'($urandom_range(0, 40)) - 32'd20;
            default: t = $urandom;
        endcase
        return t;
    endfunction

    initial begin
        logic [14:0] aop;
        logic [3:0]  dop;
        reset = 1'b1;
        ds_to_es_valid = 1'b0; ds_alu_op = '0; ds_div_op = '0;
        ds_src1 = '0; ds_src2 = '0; ds_dest = '0; ds_gr_we = 1'b0; ds_pc = '0;
        ms_allowin = 1'b1;
        model_reset();
        #12;
        chk("rst es_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
        chk("rst es_busy", 32'(es_busy), 32'd0);
        chk("rst es_allowin", 32'(es_allowin), 32'd1);
        chk("rst alu_op", 32'(alu_op), 32'd0);
        chk("rst es_result", es_result, 32'd0);
        chk("rst es_pc", es_pc, 32'd0);
        #6 reset = 1'b0;
        @(posedge clk); #1;

        step(1'b1, OP_ADD, '0, 32'd5, 32'd7, 1'b1);
        step(1'b1, OP_SUB, '0, 32'd3, 32'd10, 1'b1);
        idle(2, 1'b1);

        do_div(DIV_W, 32'hFFFF_FFF9, 32'd2);
        do_div(MOD_W, 32'hFFFF_FFF9, 32'd2);
        do_div(DIV_WU, 32'hFFFF_FFFF, 32'h10);
        do_div(DIV_W, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div(MOD_W, 32'd9, 32'd0);
        do_div(MOD_WU, 32'd100, 32'd7);
        do_div(DIV_W, 32'd8, 32'd2);

        step(1'b1, '0, DIV_W, 32'd100, 32'hFFFF_FFF9, 1'b1);
        idle(37, 1'b0);
        idle(3, 1'b1);

        step(1'b1, '0, MOD_W, 32'd50, 32'd3, 1'b1);
        idle(10, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst es_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
        chk("midrst es_busy", 32'(es_busy), 32'd0);
        chk("midrst es_allowin", 32'(es_allowin), 32'd1);
        chk("midrst alu_op", 32'(alu_op), 32'd0);
        chk("midrst es_result", es_result, 32'd0);
        model_reset();
        @(posedge clk); #2;
        reset = 1'b0;
        step(1'b1, OP_ADD, '0, 32'd20, 32'd22, 1'b1);
        idle(40, 1'b1);

        for (int i = 0; i < 500; i++) begin
            aop = 15'd1 << $urandom_range(0, 11);
            dop = '0;
            if ($urandom_range(0, 4) == 0) begin
                aop = '0;
                dop = 4'b0001 << $urandom_range(0, 3);
            end
            step($urandom_range(0, 9) < 7, aop, dop, rnd_opnd(), rnd_opnd(), $urandom_range(0, 9) < 7);
        end
        idle(40, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
